rmt_ingress_arb: RTL and testbench

Packet-granular round-robin arbiter that shares one rmt match-action pipeline between PORT_COUNT upstream AXI-Stream sources (e.g. per-MAC or per-queue ingress). It grants one source at a time, holds the grant until that packet's tlast beat is accepted, and tags every output beat with the source index on m_axis_tid. A registered output stage feeds rmt's s_axis directly.

---
 rtl/rmt_ingress_arb.sv | 191 +++++++++++++++++++
 tb/tb_rmt_ingress_arb.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmt_ingress_arb.sv
// rmt_ingress_arb: packet-granular round-robin arbiter in front of the rmt pipeline.
//
// Shares one AXI-Stream master between PORT_COUNT sources. A source is granted in IDLE and
// keeps the grant until its tlast beat is accepted. Every output beat carries the source
// index on m_axis_tid. A single output register stage drives m_axis_*.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   s_axis_*           PORT_COUNT concatenated source streams (port i at slice i)
//   m_axis_*           arbitrated stream towards rmt, m_axis_tid = source port
//   cfg_port_en        per-port arbitration enable
//   status_busy        1 while a packet is being transferred
//   status_grant       currently or most recently granted port
module rmt_ingress_arb #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int unsigned USER_WIDTH = 8,
  parameter int unsigned PORT_COUNT = 4,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORT_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [PORT_COUNT-1:0]            s_axis_tvalid,
  output logic [PORT_COUNT-1:0]            s_axis_tready,
  input  logic [PORT_COUNT-1:0]            s_axis_tlast,
  input  logic [PORT_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  input  logic [PORT_COUNT-1:0]            cfg_port_en,
  output logic                             status_busy,
  output logic [ID_WIDTH-1:0]              status_grant
);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
  logic [USER_WIDTH-1:0] m_user_q, m_user_d;
  logic [ID_WIDTH-1:0]   m_tid_q, m_tid_d;

  // Fields of the granted source
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  sel_valid;
  logic                  sel_last;

  logic                  out_ready;
  logic                  accept;
  logic [ID_WIDTH-1:0]   next_ptr;

  // Round-robin pick
  logic [PORT_COUNT-1:0] req;
  logic [PORT_COUNT-1:0] req_rot;
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  int unsigned           pick_sum;

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  assign req = s_axis_tvalid & cfg_port_en;
  // Rotate so bit 0 is the port at rr_ptr; the first set bit is then the winner.
  assign req_rot = PORT_COUNT'({req, req} >> rr_ptr_q);

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    pick_sum   = 0;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      if (!pick_found && req_rot[i]) begin
        pick_found = 1'b1;
        pick_sum   = 32'(rr_ptr_q) + i;
        if (pick_sum >= PORT_COUNT) begin
          pick_sum = pick_sum - PORT_COUNT;
        end
        pick_idx = ID_WIDTH'(pick_sum);
      end
    end
  end

  assign out_ready = !m_valid_q || m_axis_tready;
  assign accept    = (state_q == StXfer) && sel_valid && out_ready;
  assign next_ptr  = (grant_q == ID_WIDTH'(PORT_COUNT - 1)) ? '0 : grant_q + ID_WIDTH'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    m_data_d      = m_data_q;
    m_keep_d      = m_keep_q;
    m_user_d      = m_user_q;
    m_tid_d       = m_tid_q;
    s_axis_tready = '0;

    unique case (state_q)
      StIdle: begin
        // No ready here: one bubble cycle per packet while the grant registers.
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = StXfer;
        end
      end
      StXfer: begin
        for (int unsigned i = 0; i < PORT_COUNT; i++) begin
          s_axis_tready[i] = out_ready && (grant_q == ID_WIDTH'(i));
        end
        // Grant is released only by an accepted tlast, never by enable or valid drops.
        if (accept && sel_last) begin
          rr_ptr_d = next_ptr;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      m_valid_d = 1'b1;
      m_last_d  = sel_last;
      m_data_d  = sel_data;
      m_keep_d  = sel_keep;
      m_user_d  = sel_user;
      m_tid_d   = grant_q;
    end else if (out_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_user_q  <= '0;
      m_tid_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_user_q  <= m_user_d;
      m_tid_q   <= m_tid_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tid    = m_tid_q;
  assign status_busy   = (state_q == StXfer);
  assign status_grant  = grant_q;

endmodule

// File: tb/tb_rmt_ingress_arb.sv
// Directed testbench for rmt_ingress_arb: 4 ports, 32-bit data.
module tb_rmt_ingress_arb;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 8;
  localparam int PC = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [PC*DW-1:0] s_tdata  = '0;
  logic [PC*KW-1:0] s_tkeep  = '0;
  logic [PC-1:0]    s_tvalid = '0;
  logic [PC-1:0]    s_tready;
  logic [PC-1:0]    s_tlast  = '0;
  logic [PC*UW-1:0] s_tuser  = '0;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic             m_tlast;
  logic [UW-1:0]    m_tuser;
  logic [IW-1:0]    m_tid;
  logic [PC-1:0]    cfg_en = 4'hF;
  logic             busy;
  logic [IW-1:0]    grant;

  always #5 clk = ~clk;

  rmt_ingress_arb #(
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .USER_WIDTH(UW),
    .PORT_COUNT(PC),
    .ID_WIDTH  (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .s_axis_tuser (s_tuser),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser),
    .m_axis_tid   (m_tid),
    .cfg_port_en  (cfg_en),
    .status_busy  (busy),
    .status_grant (grant)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source beat tables; gap inserts one idle cycle before that beat.
  logic [31:0] src_data [PC][16];
  bit          src_last [PC][16];
  bit          src_gap  [PC][16];
  int          src_len  [PC];
  int          src_ptr  [PC];
  bit          acc      [PC];
  bit          hold     [PC];

  // Output capture
  logic [31:0] out_data [64];
  logic [7:0]  out_user [64];
  logic [3:0]  out_keep [64];
  int          out_tid  [64];
  bit          out_last [64];
  int          out_cyc  [64];
  int          out_cnt = 0;

  initial begin
    for (int i = 0; i < PC; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
      acc[i]     = 1'b0;
      hold[i]    = 1'b0;
    end
    s_tkeep = {4'hF, 4'h7, 4'h3, 4'h1};
    s_tuser = {8'h33, 8'h32, 8'h31, 8'h30};
  end

  // Source driver: handshakes sampled at negedge, inputs updated 1 after posedge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < PC; i++) acc[i] = s_tvalid[i] && s_tready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < PC; i++) begin
        if (acc[i]) begin
          src_ptr[i]++;
          hold[i] = (src_ptr[i] < src_len[i]) && src_gap[i][src_ptr[i]];
        end else begin
          hold[i] = 1'b0;
        end
        if (src_ptr[i] < src_len[i]) begin
          s_tvalid[i]         = !hold[i];
          s_tdata[i*DW +: DW] = src_data[i][src_ptr[i]];
          s_tlast[i]          = src_last[i][src_ptr[i]];
        end else begin
          s_tvalid[i]         = 1'b0;
          s_tdata[i*DW +: DW] = '0;
          s_tlast[i]          = 1'b0;
        end
      end
    end
  end

  // Output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (m_tvalid && m_tready && out_cnt < 64) begin
        out_data[out_cnt] = m_tdata;
        out_user[out_cnt] = m_tuser;
        out_keep[out_cnt] = m_tkeep;
        out_tid[out_cnt]  = int'(m_tid);
        out_last[out_cnt] = m_tlast;
        out_cyc[out_cnt]  = cyc;
        out_cnt++;
      end
    end
  end

  task automatic add_beat(input int p, input logic [31:0] d, input bit last, input bit gap);
    src_data[p][src_len[p]] = d;
    src_last[p][src_len[p]] = last;
    src_gap[p][src_len[p]]  = gap;
    src_len[p]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < PC; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
      acc[i]     = 1'b0;
      hold[i]    = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_out(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && out_cnt < n; k++) begin
      @(negedge clk);
      #1;
    end
    check_eq(tag, 64'(out_cnt >= n), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_src();
    out_cnt = 0;
    cycles(2);
    rst = 1'b1;
    cycles(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int start;
  int exp_fair [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  logic [31:0] exp_atom [7] = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hC0, 32'hC1};
  int exp_atom_tid [7] = '{0, 0, 0, 0, 0, 1, 1};
  logic [31:0] exp_en [6] = '{32'hF10, 32'hF11, 32'hF12, 32'hF30, 32'hF31, 32'hF32};
  int exp_en_tid [6] = '{1, 1, 1, 3, 3, 3};

  initial begin
    // Reset values
    #1 rst = 1'b0;
    cycles(2);
    check_eq("rst_m_valid", m_tvalid, 0);
    check_eq("rst_m_last", m_tlast, 0);
    check_eq("rst_m_data", m_tdata, 0);
    check_eq("rst_m_tid", m_tid, 0);
    check_eq("rst_s_ready", s_tready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant", grant, 0);
    rst = 1'b1;
    cycles(2);

    // Single source, port 2, 3 beats
    add_beat(2, 32'hA1, 0, 0);
    add_beat(2, 32'hA2, 0, 0);
    add_beat(2, 32'hA3, 1, 0);
    start = cyc;
    check_eq("idle_ready", s_tready, 0);
    cycles(2);
    check_eq("single_busy", busy, 1);
    check_eq("single_grant", grant, 2);
    wait_out(3, 20, "single_done");
    for (int i = 0; i < 3; i++) begin
      check_eq("single_data", out_data[i], 64'hA1 + 64'(i));
      check_eq("single_tid", out_tid[i], 2);
      check_eq("single_last", out_last[i], (i == 2) ? 1 : 0);
    end
    check_eq("single_first_cyc", out_cyc[0], start + 3);
    check_eq("single_last_cyc", out_cyc[2], start + 5);
    check_eq("single_user", out_user[0], 8'h32);
    check_eq("single_keep", out_keep[0], 4'h7);
    cycles(3);
    check_eq("single_idle", busy, 0);

    // Fairness: every port has two 2-beat packets
    do_reset();
    for (int p = 0; p < PC; p++) begin
      for (int k = 0; k < 2; k++) begin
        add_beat(p, 32'(p * 256 + k * 16), 0, 0);
        add_beat(p, 32'(p * 256 + k * 16 + 1), 1, 0);
      end
    end
    wait_out(16, 200, "fair_done");
    for (int i = 0; i < 10; i++) begin
      check_eq("fair_tid", out_tid[i], exp_fair[i]);
      check_eq("fair_data", out_data[i], 64'(exp_fair[i] * 256 + (i / 8) * 16 + (i % 2)));
    end
    check_eq("fair_back2back", out_cyc[1] - out_cyc[0], 1);
    check_eq("fair_bubble", out_cyc[2] - out_cyc[1], 2);

    // Packet atomicity with tvalid gaps on port 0
    do_reset();
    add_beat(0, 32'hB0, 0, 0);
    add_beat(0, 32'hB1, 0, 0);
    add_beat(0, 32'hB2, 0, 1);
    add_beat(0, 32'hB3, 0, 0);
    add_beat(0, 32'hB4, 1, 1);
    add_beat(1, 32'hC0, 0, 0);
    add_beat(1, 32'hC1, 1, 0);
    wait_out(7, 100, "atom_done");
    for (int i = 0; i < 7; i++) begin
      check_eq("atom_data", out_data[i], exp_atom[i]);
      check_eq("atom_tid", out_tid[i], exp_atom_tid[i]);
    end
    check_eq("atom_last0", out_last[4], 1);
    check_eq("atom_last1", out_last[6], 1);

    // Backpressure mid-packet on port 3
    do_reset();
    for (int b = 0; b < 6; b++) add_beat(3, 32'hE0 + 32'(b), (b == 5), 0);
    wait_out(2, 50, "bp_start");
    @(posedge clk);
    #1 m_tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check_eq("bp_valid", m_tvalid, 1);
      check_eq("bp_data", m_tdata, 32'hE2);
      check_eq("bp_tid", m_tid, 3);
      check_eq("bp_last", m_tlast, 0);
      check_eq("bp_s_ready", s_tready, 0);
      check_eq("bp_count", out_cnt, 2);
    end
    @(posedge clk);
    #1 m_tready = 1'b1;
    wait_out(6, 50, "bp_done");
    cycles(5);
    check_eq("bp_total", out_cnt, 6);
    for (int i = 0; i < 6; i++) check_eq("bp_seq", out_data[i], 32'hE0 + 32'(i));
    check_eq("bp_tlast", out_last[5], 1);

    // Enable mask, port 1 disabled mid-packet
    do_reset();
    cfg_en = 4'b1010;
    for (int p = 0; p < PC; p++) begin
      for (int b = 0; b < 3; b++) add_beat(p, 32'hF00 + 32'(p * 16 + b), (b == 2), 0);
    end
    wait_out(1, 30, "en_start");
    cfg_en = 4'b1000;
    wait_out(6, 100, "en_done");
    cycles(20);
    check_eq("en_total", out_cnt, 6);
    for (int i = 0; i < 6; i++) begin
      check_eq("en_tid", out_tid[i], exp_en_tid[i]);
      check_eq("en_data", out_data[i], exp_en[i]);
    end
    check_eq("en_idle", busy, 0);
    clear_src();
    cycles(2);
    cfg_en = 4'hF;

    // Reset mid-packet: rr_ptr is 2 after port 1, port 2 cut off in beat 2
    out_cnt = 0;
    add_beat(1, 32'hD0, 1, 0);
    for (int b = 0; b < 4; b++) add_beat(2, 32'hD1 + 32'(b), (b == 3), 0);
    wait_out(3, 50, "mid_start");
    check_eq("mid_third", out_data[2], 32'hD2);
    rst = 1'b0;
    #1;
    check_eq("mid_m_valid", m_tvalid, 0);
    check_eq("mid_s_ready", s_tready, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_grant", grant, 0);
    check_eq("mid_data", m_tdata, 0);
    clear_src();
    out_cnt = 0;
    cycles(2);
    rst = 1'b1;
    cycles(1);
    check_eq("post_busy", busy, 0);
    check_eq("post_valid", m_tvalid, 0);
    add_beat(0, 32'h70, 1, 0);
    add_beat(3, 32'h73, 1, 0);
    wait_out(2, 50, "post_done");
    check_eq("post_rr_first", out_tid[0], 0);
    check_eq("post_rr_second", out_tid[1], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
